// File: rtl/pipeline_scheduler_pkg.sv
// rtl/pipeline_scheduler_pkg.sv - shared widths, ID state encoding and defaults for the scheduler
package pipeline_scheduler_pkg;

   localparam int ADDRESS_WIDTH   = 16;
   localparam int ID_WIDTH        = 3;
   localparam int PIPELINE_DEPTH  = 4;
   localparam int NUM_REQ_DEFAULT = 4;
   localparam int NUM_IDS         = 1 << ID_WIDTH;
   localparam int DRAIN_WIDTH     = $clog2(PIPELINE_DEPTH + 1);

   typedef enum logic [1:0] {
      ID_FREE  = 2'd0,
      ID_BUSY  = 2'd1,
      ID_DRAIN = 2'd2
   } id_state_e;

endpackage

// File: rtl/pipeline_scheduler_rr_arbiter.sv
// rtl/pipeline_scheduler_rr_arbiter.sv - round-robin arbiter, priority starts after the last winner
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  req,
   input  logic          en,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] grant_idx
);

   logic [PW-1:0] ptr_q, ptr_d;
   logic          found;
   int            idx;

   // ptr_q holds the requester with highest priority this cycle
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      ptr_d     = ptr_q;
      found     = 1'b0;
      idx       = 0;
      for (int i = 0; i < N; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= N) idx = idx - N;
         if (en && !found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = PW'(idx);
            ptr_d      = (idx == N - 1) ? '0 : PW'(idx + 1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/pipeline_scheduler.sv
// rtl/pipeline_scheduler.sv - ID allocation, issue, cancel/drain and retire for a shared pipeline
module pipeline_scheduler
   import pipeline_scheduler_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEFAULT,
   localparam int OWNER_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_address,
   output logic [NUM_REQ-1:0]               req_ready,
   output logic [ID_WIDTH-1:0]              req_id,
   input  logic                             cancel_valid,
   input  logic [ID_WIDTH-1:0]              cancel_id,
   output logic [ADDRESS_WIDTH-1:0]         pipe_address,
   output logic [ID_WIDTH-1:0]              pipe_id,
   output logic                             pipe_valid,
   output logic                             pipe_flush,
   output logic [ID_WIDTH-1:0]              pipe_flush_id,
   output logic                             pipe_stall,
   input  logic [ADDRESS_WIDTH-1:0]         pipe_out_address,
   input  logic [ID_WIDTH-1:0]              pipe_out_id,
   input  logic                             pipe_out_valid,
   output logic                             rsp_valid,
   output logic [ADDRESS_WIDTH-1:0]         rsp_address,
   output logic [ID_WIDTH-1:0]              rsp_id,
   output logic [OWNER_WIDTH-1:0]           rsp_owner,
   input  logic                             rsp_ready,
   output logic [ID_WIDTH:0]                busy_count
);

   id_state_e              state_q [NUM_IDS];
   id_state_e              state_d [NUM_IDS];
   logic [OWNER_WIDTH-1:0] owner_q [NUM_IDS];
   logic [OWNER_WIDTH-1:0] owner_d [NUM_IDS];
   logic [DRAIN_WIDTH-1:0] drain_q [NUM_IDS];
   logic [DRAIN_WIDTH-1:0] drain_d [NUM_IDS];
   logic [ID_WIDTH:0]      busy_count_q, busy_count_d;

   logic                   exit_busy, cancel_busy, cancel_exit, retire;
   logic                   alloc_found, grant_en;
   logic [ID_WIDTH-1:0]    alloc_id;
   logic [NUM_REQ-1:0]     grant;
   logic [OWNER_WIDTH-1:0] grant_idx;

   // A cancel hitting the exiting ID kills the response outright instead of draining
   assign exit_busy   = pipe_out_valid && (state_q[pipe_out_id] == ID_BUSY);
   assign cancel_busy = !reset && cancel_valid && (state_q[cancel_id] == ID_BUSY);
   assign cancel_exit = cancel_busy && pipe_out_valid && (cancel_id == pipe_out_id);
   assign rsp_valid   = !reset && exit_busy && !cancel_exit;
   assign pipe_stall  = rsp_valid && !rsp_ready;
   assign retire      = rsp_valid && rsp_ready;

   assign rsp_address = pipe_out_address;
   assign rsp_id      = pipe_out_id;
   assign rsp_owner   = owner_q[pipe_out_id];

   assign pipe_flush    = cancel_busy;
   assign pipe_flush_id = cancel_id;

   // Search current state only, so IDs freed this cycle wait until next cycle
   always_comb begin
      alloc_found = 1'b0;
      alloc_id    = '0;
      for (int i = NUM_IDS - 1; i >= 0; i--) begin
         if (state_q[i] == ID_FREE) begin
            alloc_found = 1'b1;
            alloc_id    = ID_WIDTH'(i);
         end
      end
   end

   assign grant_en = !reset && !pipe_stall && alloc_found;

   rr_arbiter #(
      .N  (NUM_REQ),
      .PW (OWNER_WIDTH)
   ) u_arb (
      .clk       (clk),
      .reset     (reset),
      .req       (req_valid),
      .en        (grant_en),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign req_ready    = grant;
   assign pipe_valid   = |grant;
   assign req_id       = alloc_id;
   assign pipe_id      = alloc_id;
   assign pipe_address = req_address[int'(grant_idx) * ADDRESS_WIDTH +: ADDRESS_WIDTH];

   always_comb begin
      busy_count_d = '0;
      for (int i = 0; i < NUM_IDS; i++) begin
         state_d[i] = state_q[i];
         owner_d[i] = owner_q[i];
         drain_d[i] = drain_q[i];
         if (state_q[i] == ID_DRAIN && !pipe_stall) begin
            if (drain_q[i] <= DRAIN_WIDTH'(1)) begin
               state_d[i] = ID_FREE;
               drain_d[i] = '0;
            end else begin
               drain_d[i] = drain_q[i] - DRAIN_WIDTH'(1);
            end
         end
         if (retire && pipe_out_id == ID_WIDTH'(i)) state_d[i] = ID_FREE;
         if (cancel_busy && cancel_id == ID_WIDTH'(i)) begin
            if (cancel_exit) begin
               state_d[i] = ID_FREE;
            end else begin
               state_d[i] = ID_DRAIN;
               drain_d[i] = DRAIN_WIDTH'(PIPELINE_DEPTH);
            end
         end
         if (pipe_valid && alloc_id == ID_WIDTH'(i)) begin
            state_d[i] = ID_BUSY;
            owner_d[i] = grant_idx;
         end
         if (state_d[i] != ID_FREE) busy_count_d = busy_count_d + (ID_WIDTH + 1)'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_IDS; i++) begin
            state_q[i] <= ID_FREE;
            owner_q[i] <= '0;
            drain_q[i] <= '0;
         end
         busy_count_q <= '0;
      end else begin
         for (int i = 0; i < NUM_IDS; i++) begin
            state_q[i] <= state_d[i];
            owner_q[i] <= owner_d[i];
            drain_q[i] <= drain_d[i];
         end
         busy_count_q <= busy_count_d;
      end
   end

   assign busy_count = busy_count_q;

endmodule

// File: tb/tb_pipeline_scheduler.sv
// tb/tb_pipeline_scheduler.sv - scoreboard bench with a reference model and a modelled pipeline
module tb_pipeline_scheduler;
   import pipeline_scheduler_pkg::*;

   localparam int NR = 4;
   localparam int AW = ADDRESS_WIDTH;
   localparam int IW = ID_WIDTH;
   localparam int NI = NUM_IDS;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [NR-1:0]    req_valid = '0;
   logic [NR*AW-1:0] req_address = '0;
   logic [NR-1:0]    req_ready;
   logic [IW-1:0]    req_id;
   logic             cancel_valid = 1'b0;
   logic [IW-1:0]    cancel_id = '0;
   logic [AW-1:0]    pipe_address;
   logic [IW-1:0]    pipe_id;
   logic             pipe_valid, pipe_flush, pipe_stall;
   logic [IW-1:0]    pipe_flush_id;
   logic [AW-1:0]    pipe_out_address = '0;
   logic [IW-1:0]    pipe_out_id = '0;
   logic             pipe_out_valid = 1'b0;
   logic             rsp_valid;
   logic [AW-1:0]    rsp_address;
   logic [IW-1:0]    rsp_id;
   logic [1:0]       rsp_owner;
   logic             rsp_ready = 1'b1;
   logic [IW:0]      busy_count;

   pipeline_scheduler #(.NUM_REQ(NR)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_address(req_address),
      .req_ready(req_ready), .req_id(req_id), .cancel_valid(cancel_valid), .cancel_id(cancel_id),
      .pipe_address(pipe_address), .pipe_id(pipe_id), .pipe_valid(pipe_valid),
      .pipe_flush(pipe_flush), .pipe_flush_id(pipe_flush_id), .pipe_stall(pipe_stall),
      .pipe_out_address(pipe_out_address), .pipe_out_id(pipe_out_id), .pipe_out_valid(pipe_out_valid),
      .rsp_valid(rsp_valid), .rsp_address(rsp_address), .rsp_id(rsp_id), .rsp_owner(rsp_owner),
      .rsp_ready(rsp_ready), .busy_count(busy_count)
   );

   always #5 clk = ~clk;

   typedef struct { int id; logic [AW-1:0] addr; int owner; } rsp_t;
   typedef struct { logic v; logic [IW-1:0] id; logic [AW-1:0] a; } stage_t;

   // Reference: 0 = free, 1 = in flight, 2 = cancelled and waiting out the pipeline
   int     m_st [NI];
   int     m_drain [NI];
   int     m_next;
   rsp_t   exp_q [$];
   stage_t stg [16];
   int     lat = 4;
   int     n_cmp = 0;
   int     n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int lowest_free();
      for (int i = 0; i < NI; i++) if (m_st[i] == 0) return i;
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin m_st[i] = 0; m_drain[i] = 0; end
      m_next = 0;
      exp_q.delete();
   endtask

   task automatic clear_pipe();
      for (int i = 0; i < 16; i++) stg[i] = '{1'b0, '0, '0};
   endtask

   task automatic step(input logic [NR-1:0] rv, input logic cv, input int cid,
                       input logic rrdy, input logic rst);
      int g, fid, nbusy, poid;
      logic exit_busy, cbusy, cexit, ersp, estall, any_free;
      logic [NR-1:0] eready;
      logic [AW-1:0] gaddr;
      @(posedge clk);
      #1;
      reset        = rst;
      req_valid    = rv;
      for (int r = 0; r < NR; r++) req_address[r*AW +: AW] = AW'($urandom);
      cancel_valid = cv;
      cancel_id    = IW'(cid);
      rsp_ready    = rrdy;
      pipe_out_valid   = stg[lat-1].v;
      pipe_out_id      = stg[lat-1].id;
      pipe_out_address = stg[lat-1].a;
      #1;
      if (rst) begin
         model_reset();
         chk("rst_req_ready", 64'(req_ready), 0);
         chk("rst_pipe_valid", 64'(pipe_valid), 0);
         chk("rst_pipe_flush", 64'(pipe_flush), 0);
         chk("rst_rsp_valid", 64'(rsp_valid), 0);
         chk("rst_pipe_stall", 64'(pipe_stall), 0);
         chk("rst_busy_count", 64'(busy_count), 0);
      end else begin
         poid      = int'(pipe_out_id);
         exit_busy = pipe_out_valid && m_st[poid] == 1;
         cbusy     = cv && m_st[cid] == 1;
         cexit     = cbusy && pipe_out_valid && cid == poid;
         ersp      = exit_busy && !cexit;
         estall    = ersp && !rrdy;
         fid       = lowest_free();
         any_free  = fid >= 0;
         g = -1;
         if (!estall && any_free)
            for (int k = 0; k < NR; k++)
               if (g < 0 && rv[(m_next + k) % NR]) g = (m_next + k) % NR;
         eready = '0;
         if (g >= 0) eready[g] = 1'b1;
         nbusy = 0;
         for (int i = 0; i < NI; i++) if (m_st[i] != 0) nbusy++;
         chk("req_ready", 64'(req_ready), 64'(eready));
         chk("pipe_valid", 64'(pipe_valid), 64'(g >= 0));
         if (g >= 0) begin
            gaddr = req_address[g*AW +: AW];
            chk("req_id", 64'(req_id), 64'(fid));
            chk("pipe_id", 64'(pipe_id), 64'(fid));
            chk("pipe_address", 64'(pipe_address), 64'(gaddr));
         end
         chk("pipe_flush", 64'(pipe_flush), 64'(cbusy));
         if (cbusy) chk("pipe_flush_id", 64'(pipe_flush_id), 64'(cid));
         chk("pipe_stall", 64'(pipe_stall), 64'(estall));
         chk("rsp_valid", 64'(rsp_valid), 64'(ersp));
         chk("busy_count", 64'(busy_count), 64'(nbusy));
         if (!estall)
            for (int i = 0; i < NI; i++)
               if (m_st[i] == 2) begin
                  m_drain[i]--;
                  if (m_drain[i] == 0) m_st[i] = 0;
               end
         if (ersp && rrdy) m_st[poid] = 0;
         if (cbusy) begin
            if (cexit) m_st[cid] = 0;
            else begin m_st[cid] = 2; m_drain[cid] = PIPELINE_DEPTH; end
            for (int j = exp_q.size() - 1; j >= 0; j--)
               if (exp_q[j].id == cid) exp_q.delete(j);
         end
         if (g >= 0) begin
            m_st[fid] = 1;
            m_next = (g + 1) % NR;
            exp_q.push_back('{fid, gaddr, g});
         end
      end
      if (!pipe_stall) begin
         for (int i = lat - 1; i > 0; i--) stg[i] = stg[i-1];
         stg[0] = '{pipe_valid, pipe_id, pipe_address};
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step('0, 1'b0, 0, 1'b1, 1'b0);
   endtask

   initial begin : monitor
      rsp_t e;
      forever begin
         @(negedge clk);
         if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               chk("rsp_unexpected_id", 64'(rsp_id), 64'hFFFF);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_id", 64'(rsp_id), 64'(e.id));
               chk("rsp_address", 64'(rsp_address), 64'(e.addr));
               chk("rsp_owner", 64'(rsp_owner), 64'(e.owner));
            end
         end
      end
   end

   initial begin : stimulus
      int id, n;
      model_reset();
      clear_pipe();
      step(4'hF, 1'b1, 0, 1'b1, 1'b1);
      step(4'hF, 1'b0, 0, 1'b1, 1'b1);

      // single issue then drain to empty
      step(4'b0001, 1'b0, 0, 1'b1, 1'b0);
      idle(8);

      // all requesters with a long pipeline: eight grants, then IDs exhausted
      lat = 10;
      clear_pipe();
      for (int i = 0; i < 9; i++) step(4'hF, 1'b0, 0, 1'b1, 1'b0);
      idle(14);
      lat = 4;
      clear_pipe();

      // backpressure at first exit
      step(4'b0001, 1'b0, 0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) step(4'hF, 1'b0, 0, 1'b0, 1'b0);
      idle(10);

      // cancel an in-flight ID one cycle after issue
      id = lowest_free();
      step(4'b0100, 1'b0, 0, 1'b1, 1'b0);
      step('0, 1'b1, id, 1'b1, 1'b0);
      idle(8);

      // cancel exactly as the ID exits, then cancel a free ID
      step(4'b0010, 1'b0, 0, 1'b1, 1'b0);
      n = 0;
      while (!stg[lat-1].v && n < 10) begin idle(1); n++; end
      chk("exit_reached", 64'(stg[lat-1].v), 1);
      step('0, 1'b1, int'(stg[lat-1].id), 1'b1, 1'b0);
      step('0, 1'b1, 5, 1'b1, 1'b0);
      idle(6);

      // reset with three outstanding; stale exits must be suppressed
      for (int i = 0; i < 3; i++) step(4'b0001, 1'b0, 0, 1'b1, 1'b0);
      step(4'hF, 1'b0, 0, 1'b1, 1'b1);
      idle(lat + 2);

      // randomized traffic
      for (int i = 0; i < 600; i++)
         step(NR'($urandom), ($urandom % 6) == 0, int'($urandom % NI),
              ($urandom % 4) != 0, 1'b0);
      idle(20);
      chk("scoreboard_empty", 64'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipeline_scheduler.md
PIPELINE_SCHEDULER -- requirements
Module: pipeline_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the pipeline (2..8).
REQ-002 Widths `ADDRESS_WIDTH, `ID_WIDTH and `PIPELINE_DEPTH SHALL come from defines.vh; ID space is 2^`ID_WIDTH entries.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  NUM_REQ  per-requester issue request.
REQ-006 req_address  input  NUM_REQ*`ADDRESS_WIDTH  per-requester address, requester r at slice r.
REQ-007 req_ready  output  NUM_REQ  one-hot grant; transfer when req_valid[r] && req_ready[r].
REQ-008 req_id  output  `ID_WIDTH  ID allocated to the granted request, valid with grant.
REQ-009 cancel_valid, cancel_id  input  1, `ID_WIDTH  request to kill an outstanding ID.
REQ-010 pipe_address, pipe_id, pipe_valid  output  `ADDRESS_WIDTH, `ID_WIDTH, 1  pipeline entry.
REQ-011 pipe_flush, pipe_flush_id  output  1, `ID_WIDTH  pipeline flush port.
REQ-012 pipe_stall  output  1  global pipeline stall.
REQ-013 pipe_out_address, pipe_out_id, pipe_out_valid  input  `ADDRESS_WIDTH, `ID_WIDTH, 1  pipeline exit.
REQ-014 rsp_valid, rsp_address, rsp_id, rsp_owner  output  1, `ADDRESS_WIDTH, `ID_WIDTH, clog2(NUM_REQ)  response.
REQ-015 rsp_ready  input  1  response consumer ready.
REQ-016 busy_count  output  `ID_WIDTH+1  number of IDs not FREE.

Function
REQ-017 Each ID SHALL hold a state FREE, BUSY or DRAIN, plus a stored owner index.
REQ-018 rsp_valid SHALL equal pipe_out_valid && state[pipe_out_id]==BUSY; rsp_address/rsp_id pass through combinationally; rsp_owner = owner[pipe_out_id].
REQ-019 pipe_stall SHALL equal rsp_valid && !rsp_ready (combinational).
REQ-020 Grant SHALL occur only when pipe_stall==0 and at least one ID is FREE; otherwise req_ready==0.
REQ-021 Arbitration SHALL be round-robin: priority starts at requester after the last granted one; pointer updates only on a grant.
REQ-022 Allocated ID SHALL be the lowest-numbered FREE ID; on grant it becomes BUSY and owner is recorded next edge.
REQ-023 pipe_valid SHALL equal the grant; pipe_address/pipe_id SHALL carry the granted address and req_id in the same cycle (zero-latency issue).
REQ-024 Retire: when rsp_valid && rsp_ready, ID pipe_out_id SHALL return to FREE next edge.
REQ-025 Exit with state DRAIN or FREE SHALL be suppressed (rsp_valid=0, no stall).
REQ-026 Cancel of a BUSY ID SHALL assert pipe_flush=1, pipe_flush_id=cancel_id in the same cycle and move the ID to DRAIN with a drain counter loaded to `PIPELINE_DEPTH.
REQ-027 Drain counter SHALL decrement only in cycles with pipe_stall==0; at zero the ID returns to FREE.
REQ-028 Cancel of a FREE or DRAIN ID SHALL be ignored (pipe_flush=0).
REQ-029 Cancel of the ID exiting in the same cycle SHALL suppress that response and free the ID next edge (no DRAIN).
REQ-030 A freed ID SHALL not be allocated in the same cycle it is freed; it becomes allocatable next cycle.
REQ-031 Grant and cancel in the same cycle SHALL both be honoured; the newly allocated ID is never the cancelled one.
REQ-032 busy_count SHALL track BUSY+DRAIN IDs exactly, registered.

Reset
REQ-033 On reset all IDs FREE, drain counters 0, RR pointer 0, busy_count 0; outputs req_ready, pipe_valid, pipe_flush, rsp_valid, pipe_stall SHALL be 0 while reset is high.
REQ-034 Reset mid-operation SHALL discard all outstanding IDs; exits after reset deassertion are suppressed per REQ-025.

Structure
REQ-035 ID state encodings and NUM_REQ default SHALL live in defines.vh alongside the existing width macros.
REQ-036 Round-robin arbitration SHALL be one sub-module, rr_arbiter (req vector, enable, one-hot grant, pointer).

Verification (NUM_REQ=4, ID_WIDTH=3, PIPELINE_DEPTH=4)
REQ-037 Single issue: req_valid=0001, addr 0x10 -> req_ready=0001, pipe_id=0; response id 0 owner 0 after 4 cycles; busy_count 1->0.
REQ-038 Fairness: req_valid=1111 held 8 cycles -> grants 0,1,2,3,0,1,2,3; IDs 0..7; 9th cycle no grant (IDs exhausted).
REQ-039 Backpressure: rsp_ready=0 at first exit -> pipe_stall=1, no grants, rsp held stable until rsp_ready=1.
REQ-040 Cancel: issue ID 2, cancel_id=2 next cycle -> pipe_flush=1 id 2; ID 2 DRAIN, FREE after 4 unstalled cycles; no response for ID 2.
REQ-041 Corner: cancel_id equals exiting pipe_out_id -> rsp_valid=0, ID freed next edge; cancel of FREE ID 5 -> pipe_flush=0.
REQ-042 Reset asserted with 3 IDs outstanding -> busy_count=0, all outputs 0, subsequent exits suppressed.
